sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter that shares one synchronous sprite ROM read port among several pixel renderers (player, obstacle 1, obstacle 2). It sits between the renderers' ROM-counter/sprite-select outputs and a single merged sprite ROM. Each grant issues one ROM read and routes the returned pixel bit back to its owner through a tagged return pipeline. Its purpose is to replace the per-renderer ROM instances.

## Interface

Parameters:
- `NREQ`, default 3: number of requesters. Requester 0 is the player, 1 is obstacle 1, 2 is obstacle 2.
- `ADDR_W`, default 8: ROM pixel-address width per requester.
- `SEL_W`, default 3: sprite-select width (player state or obstacle type).
- `LAT`, default 1: ROM read latency in cycles. Legal range 1..2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `i_req`  in  NREQ: level request per requester. Held until granted.
- `i_addr`  in  NREQ*ADDR_W: packed addresses. Requester k uses bits [k*ADDR_W +: ADDR_W].
- `i_sel`  in  NREQ*SEL_W: packed sprite selects. Requester k uses bits [k*SEL_W +: SEL_W].
- `i_frame_start`  in  1: one-cycle pulse at start of frame. Restarts priority at requester 0.
- `o_gnt`  out  NREQ: one-hot grant, one-cycle pulse.
- `o_rom_en`  out  1: ROM read strobe.
- `o_rom_addr`  out  ADDR_W: ROM address of the granted requester.
- `o_rom_sel`  out  SEL_W: sprite select of the granted requester.
- `i_rom_data`  in  1: ROM pixel bit. Valid LAT cycles after `o_rom_en`.
- `o_data`  out  NREQ: per-requester registered sprite bit. Holds its last value between updates.
- `o_valid`  out  NREQ: one-cycle pulse when the matching `o_data` bit updates.

## Operation

- **Eligible requests:** `elig = i_req & ~o_gnt`. A requester that is being granted this cycle is ignored for this cycle. A held request therefore cannot take two consecutive grants.
- **Effective pointer:** `ptr_eff = i_frame_start ? 0 : ptr`.
- **Winner selection:** the winner w is the first eligible index scanning ptr_eff, ptr_eff+1, … modulo NREQ.
- **Registered on each rising edge when any bit of elig is set:**
  - `o_gnt <= onehot(w)`
  - `o_rom_en <= 1`
  - `o_rom_addr <= i_addr[w]`
  - `o_rom_sel <= i_sel[w]`
  - `ptr <= (w+1) mod NREQ`, wrapping from NREQ-1 to 0.
- **Idle edge (no eligible request):**
  - `o_gnt <= 0` and `o_rom_en <= 0`.
  - `o_rom_addr` and `o_rom_sel` hold their values.
  - `ptr <= ptr_eff`, so a `i_frame_start` pulse during an idle edge still resets the pointer.
- **Return pipeline:** a tag pipeline of depth LAT carries `o_gnt` alongside the read. When a tag emerges with owner k:
  - `o_data[k] <= i_rom_data`
  - `o_valid[k] <= 1`
  - all other `o_valid` bits go to 0.
- **Frame start:** `i_frame_start` never flushes in-flight reads.
- **Arbitration state:** there is no FSM beyond `ptr` and the tag pipeline. Throughput is one read per cycle.

## Timing

- **Reset values:** asserting `rst_n` low immediately clears the following outputs and state to 0:
  - outputs `o_gnt`, `o_rom_en`, `o_rom_addr`, `o_rom_sel`, `o_data`, `o_valid`
  - internal state `ptr` and the tag pipeline.
- **Request to grant:** a request sampled at edge E produces `o_gnt`, `o_rom_en` and the address during cycle E+1.
- **Grant to data:** a grant in cycle G produces `o_valid`/`o_data` in cycle G+LAT+1. With LAT=1 this is G+2.
- **Request to data:** 3 cycles for a lone requester with LAT=1.
- **Reset mid-read:** in-flight tags are discarded and no `o_valid` pulse follows the deassertion of reset.
- **Simultaneous events:** `i_frame_start` and a pending request on the same edge resolve with pointer 0. The new `ptr` is `w+1`.
- **Steady state:**
  - All NREQ requesters held high are granted 0,1,2,0,1,2… on consecutive cycles, and `o_rom_en` stays high continuously.
  - A single requester held high is granted every other cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle with `i_req`=111 → all outputs 0 asynchronously. After release the first grant is `o_gnt`=001.
- **Single read (LAT=1):** `i_req`=010, `i_addr[1]`=0x2A, `i_sel[1]`=3 at edge E, ROM model returns 1 → cycle E+1 shows `o_gnt`=010, `o_rom_addr`=0x2A, `o_rom_sel`=3. Cycle E+3 shows `o_valid`=010 and `o_data[1]`=1; `o_data[1]` holds 1 afterwards.
- **Round robin:** `i_req`=111 held for 6 cycles from reset → `o_gnt` sequence 001,010,100,001,010,100. Each `o_valid` appears 2 cycles after its grant, with the correct per-address ROM bit.
- **Pointer wrap:** after a grant to requester 1 (ptr=2), `i_req`=101 → `o_gnt`=100 first, then 001.
- **Frame start:** ptr=2, `i_req`=101, `i_frame_start`=1 on the same edge → `o_gnt`=001 first, then 100.
- **Reset mid-read:** a grant is issued, then `rst_n`=0 in the following cycle → no `o_valid` pulse and `o_data`=000.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM port among the pixel renderers,
// with a tagged return pipeline that routes each fetched pixel bit back to its owner.
module sprite_rom_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 3,
  parameter int LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*ADDR_W-1:0]  i_addr,
  input  logic [NREQ*SEL_W-1:0]   i_sel,
  input  logic                    i_frame_start,
  output logic [NREQ-1:0]         o_gnt,
  output logic                    o_rom_en,
  output logic [ADDR_W-1:0]       o_rom_addr,
  output logic [SEL_W-1:0]        o_rom_sel,
  input  logic                    i_rom_data,
  output logic [NREQ-1:0]         o_data,
  output logic [NREQ-1:0]         o_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [SEL_W-1:0]  rom_sel_q, rom_sel_d;
  logic [PW-1:0]     ptr_q, ptr_d, ptr_eff, win;
  logic [PW:0]       idx;
  logic              found, any_elig;
  logic [NREQ-1:0]   elig, data_q, valid_q, tag_out;
  logic [NREQ-1:0]   tag_q [LAT];

  always_comb begin
    elig       = i_req & ~gnt_q;
    any_elig   = |elig;
    ptr_eff    = i_frame_start ? '0 : ptr_q;
    win        = ptr_eff;
    found      = 1'b0;
    idx        = '0;
    gnt_d      = '0;
    rom_addr_d = rom_addr_q;
    rom_sel_d  = rom_sel_q;
    // Scan ptr_eff, ptr_eff+1, ... modulo NREQ; first eligible index wins.
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_eff} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (any_elig && win == PW'(k)) begin
        gnt_d[k]   = 1'b1;
        rom_addr_d = i_addr[k*ADDR_W +: ADDR_W];
        rom_sel_d  = i_sel[k*SEL_W +: SEL_W];
      end
    end
    ptr_d = ptr_eff;
    if (any_elig) ptr_d = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
  end

  assign tag_out = tag_q[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
      ptr_q      <= '0;
      data_q     <= '0;
      valid_q    <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rom_en_q   <= any_elig;
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
      ptr_q      <= ptr_d;
      tag_q[0]   <= gnt_q;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      // Tag leaving the pipeline lines up with the ROM bit of the same read.
      valid_q    <= tag_out;
      data_q     <= (data_q & ~tag_out) | (tag_out & {NREQ{i_rom_data}});
    end
  end

  assign o_gnt      = gnt_q;
  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = rom_addr_q;
  assign o_rom_sel  = rom_sel_q;
  assign o_data     = data_q;
  assign o_valid    = valid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (NREQ=3, LAT=1) with a parity-based ROM model.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  i_req;
  logic [23:0] i_addr;
  logic [8:0]  i_sel;
  logic        i_frame_start;
  logic [2:0]  o_gnt;
  logic        o_rom_en;
  logic [7:0]  o_rom_addr;
  logic [2:0]  o_rom_sel;
  logic        i_rom_data;
  logic [2:0]  o_data;
  logic [2:0]  o_valid;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.NREQ(3), .ADDR_W(8), .SEL_W(3), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_sel(i_sel),
    .i_frame_start(i_frame_start), .o_gnt(o_gnt), .o_rom_en(o_rom_en),
    .o_rom_addr(o_rom_addr), .o_rom_sel(o_rom_sel), .i_rom_data(i_rom_data),
    .o_data(o_data), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous ROM: pixel bit is the parity of {addr, sel}.
  always @(posedge clk) i_rom_data <= ^{o_rom_addr, o_rom_sel};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_req = 3'b000;
    i_frame_start = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [2:0] exp_gnt, exp_vld, exp_dat;
  logic [2:0] rom_bit;

  initial begin
    rst_n = 1'b0;
    i_req = 3'b000;
    i_frame_start = 1'b0;
    // Requester 0: 0x11/sel 0 -> 0; requester 1: 0x2A/sel 3 -> 1; requester 2: 0x3C/sel 4 -> 1
    i_addr = {8'h3C, 8'h2A, 8'h11};
    i_sel  = {3'd4, 3'd3, 3'd0};
    rom_bit = 3'b110;

    // Reset state
    step(); step();
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_rom_en", 32'(o_rom_en), 32'h0);
    chk("rst_rom_addr", 32'(o_rom_addr), 32'h0);
    chk("rst_rom_sel", 32'(o_rom_sel), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);

    // Asynchronous reset mid-cycle while busy, then first grant after release
    rst_n = 1'b1;
    i_req = 3'b111;
    step(); step(); step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(o_gnt), 32'h0);
    chk("async_rom_en", 32'(o_rom_en), 32'h0);
    chk("async_rom_addr", 32'(o_rom_addr), 32'h0);
    chk("async_data", 32'(o_data), 32'h0);
    chk("async_valid", 32'(o_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("first_gnt", 32'(o_gnt), 32'h1);
    chk("first_rom_en", 32'(o_rom_en), 32'h1);

    // Single read by requester 1
    do_reset();
    i_req = 3'b010;
    step();
    chk("single_gnt", 32'(o_gnt), 32'h2);
    chk("single_addr", 32'(o_rom_addr), 32'h2A);
    chk("single_sel", 32'(o_rom_sel), 32'h3);
    chk("single_en", 32'(o_rom_en), 32'h1);
    i_req = 3'b000;
    step();
    chk("single_gnt_idle", 32'(o_gnt), 32'h0);
    chk("single_vld_early", 32'(o_valid), 32'h0);
    step();
    chk("single_vld", 32'(o_valid), 32'h2);
    chk("single_dat", 32'(o_data), 32'h2);
    step();
    chk("single_vld_drop", 32'(o_valid), 32'h0);
    chk("single_dat_hold", 32'(o_data), 32'h2);

    // Round robin with all requesters held for 6 cycles
    do_reset();
    exp_dat = 3'b000;
    i_req = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_gnt = (i <= 6) ? (3'b001 << ((i - 1) % 3)) : 3'b000;
      exp_vld = (i >= 3) ? (3'b001 << ((i - 3) % 3)) : 3'b000;
      for (int k = 0; k < 3; k++) if (exp_vld[k]) exp_dat[k] = rom_bit[k];
      chk($sformatf("rr_gnt_%0d", i), 32'(o_gnt), 32'(exp_gnt));
      chk($sformatf("rr_en_%0d", i), 32'(o_rom_en), (i <= 6) ? 32'h1 : 32'h0);
      chk($sformatf("rr_vld_%0d", i), 32'(o_valid), 32'(exp_vld));
      chk($sformatf("rr_dat_%0d", i), 32'(o_data), 32'(exp_dat));
      if (i <= 6) chk($sformatf("rr_addr_%0d", i), 32'(o_rom_addr),
                      (i % 3 == 1) ? 32'h11 : (i % 3 == 2) ? 32'h2A : 32'h3C);
      if (i == 6) i_req = 3'b000;
    end

    // Lone requester held high is granted every other cycle
    do_reset();
    i_req = 3'b001;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("lone_gnt_%0d", i), 32'(o_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
    end

    // Pointer wrap: after grant to 1, request 101 -> 100 then 001
    do_reset();
    i_req = 3'b010;
    step();
    i_req = 3'b101;
    step();
    chk("wrap_gnt_a", 32'(o_gnt), 32'h4);
    step();
    chk("wrap_gnt_b", 32'(o_gnt), 32'h1);

    // Frame start on the same edge as pending requests
    do_reset();
    i_req = 3'b010;
    step();
    i_req = 3'b101;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("fs_gnt_a", 32'(o_gnt), 32'h1);
    step();
    chk("fs_gnt_b", 32'(o_gnt), 32'h4);

    // Frame start on an idle edge still resets the pointer
    do_reset();
    i_req = 3'b010;
    step();
    i_req = 3'b000;
    i_frame_start = 1'b1;
    step();
    chk("fs_idle_gnt", 32'(o_gnt), 32'h0);
    i_frame_start = 1'b0;
    i_req = 3'b101;
    step();
    chk("fs_idle_next", 32'(o_gnt), 32'h1);

    // Reset while a read is in flight discards its tag
    do_reset();
    i_req = 3'b010;
    step();
    chk("mid_gnt", 32'(o_gnt), 32'h2);
    i_req = 3'b000;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("mid_vld_%0d", i), 32'(o_valid), 32'h0);
      chk($sformatf("mid_dat_%0d", i), 32'(o_data), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
